// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB always wins, MDU results queue in order and drain on idle
// WB slots, with WAW cancel, starvation/full hold and a decode RAW stall.
module rf_write_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned STARVE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    output logic        stall_id,
    output logic        wb_hold,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [3:0]       age_q, age_d;
    logic             hold_q, hold_d;

    logic full, empty, wb_wr, head_live, head_cancel, pop, push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full        = (count_q == CntW'(DEPTH));
    assign empty       = (count_q == '0);
    assign wb_wr       = wb_valid && (wb_addr != 5'd0);
    assign head_live   = !empty && valid_q[head_q];
    assign head_cancel = head_live && wb_wr && (addr_q[head_q] == wb_addr);
    // A cancelled (invalid) head leaves the queue even while WB owns the port.
    assign pop         = !empty && (!valid_q[head_q] || !wb_wr);
    assign push        = md_valid && !full && (md_addr != 5'd0);

    assign md_ready = !full;
    assign wb_hold  = hold_q;

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = 5'd0;
        rf_wr_data = 32'd0;
        if (!reset) begin
            if (wb_wr) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = wb_addr;
                rf_wr_data = wb_data;
            end else if (head_live) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = addr_q[head_q];
                rf_wr_data = data_q[head_q];
            end
        end
    end

    always_comb begin
        stall_id = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (((id_rs_addr != 5'd0) && (addr_q[i] == id_rs_addr)) ||
                               ((id_rt_addr != 5'd0) && (addr_q[i] == id_rt_addr)))) begin
                stall_id = 1'b1;
            end
        end
        if (md_valid && (((id_rs_addr != 5'd0) && (md_addr == id_rs_addr)) ||
                         ((id_rt_addr != 5'd0) && (md_addr == id_rt_addr)))) begin
            stall_id = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_wr && (addr_q[i] == wb_addr)) begin
                valid_d[i] = 1'b0;
            end
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        // The new tail entry is set after the cancel scan, so it survives a same-cycle WB match.
        if (push) begin
            valid_d[tail_q] = 1'b1;
        end

        head_d  = pop ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CntW'(push) - CntW'(pop);

        if (pop || !head_live || head_cancel) begin
            age_d = 4'd0;
        end else if (age_q != 4'hF) begin
            age_d = age_q + 4'd1;
        end else begin
            age_d = age_q;
        end

        hold_d = (count_d == CntW'(DEPTH)) || (age_d >= 4'(STARVE - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= 4'd0;
            hold_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
            hold_q  <= hold_d;
        end
    end

    // Payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_q[tail_q] <= md_addr;
            data_q[tail_q] <= md_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a DEPTH=2 and a DEPTH=4 instance share stimulus; an MDU
// result scoreboard is checked against every port write of the instance under observation.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, md_valid;
    logic [4:0]  wb_addr, md_addr, id_rs_addr, id_rt_addr;
    logic [31:0] wb_data, md_data;

    logic        ready2, stall2, hold2, en2;
    logic [4:0]  waddr2;
    logic [31:0] wdata2;
    logic        ready4, stall4, hold4, en4;
    logic [4:0]  waddr4;
    logic [31:0] wdata4;

    logic        sel4;
    logic        obs_ready, obs_stall, obs_hold, obs_en;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;

    int checks = 0;
    int errors = 0;
    logic [36:0] md_q [$];

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(2), .STARVE(8)) dut2 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(ready2), .md_addr(md_addr), .md_data(md_data),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .stall_id(stall2), .wb_hold(hold2),
        .rf_wr_en(en2), .rf_wr_addr(waddr2), .rf_wr_data(wdata2)
    );

    rf_write_arbiter #(.DEPTH(4), .STARVE(8)) dut4 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(ready4), .md_addr(md_addr), .md_data(md_data),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .stall_id(stall4), .wb_hold(hold4),
        .rf_wr_en(en4), .rf_wr_addr(waddr4), .rf_wr_data(wdata4)
    );

    assign obs_ready = sel4 ? ready4 : ready2;
    assign obs_stall = sel4 ? stall4 : stall2;
    assign obs_hold  = sel4 ? hold4  : hold2;
    assign obs_en    = sel4 ? en4    : en2;
    assign obs_addr  = sel4 ? waddr4 : waddr2;
    assign obs_data  = sel4 ? wdata4 : wdata2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        chk(tag, 64'(got), 64'(exp));
    endtask

    // Drives one cycle of stimulus and updates the MDU result model.
    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] mdat);
        wb_valid = wv;
        wb_addr  = wa;
        wb_data  = wd;
        md_valid = mv;
        md_addr  = ma;
        md_data  = mdat;
        if (reset) begin
            md_q.delete();
        end else begin
            if (wv && (wa != 5'd0)) begin
                for (int i = md_q.size() - 1; i >= 0; i--) begin
                    if (md_q[i][36:32] == wa) md_q.delete(i);
                end
            end
            if (mv && (ma != 5'd0)) md_q.push_back({ma, mdat});
        end
    endtask

    task automatic sb_check();
        logic [36:0] exp;
        if (reset) begin
            chk1("rst_no_write", obs_en, 1'b0);
        end else if (wb_valid && (wb_addr != 5'd0)) begin
            chk("wb_write", 64'({obs_en, obs_addr, obs_data}), 64'({1'b1, wb_addr, wb_data}));
        end else if (obs_en) begin
            chk1("md_write_expected", md_q.size() != 0, 1'b1);
            if (md_q.size() != 0) begin
                exp = md_q.pop_front();
                chk("md_write", 64'({obs_addr, obs_data}), 64'(exp));
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        sb_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel4 = 1'b0;
        reset = 1'b1;
        id_rs_addr = 5'd0;
        id_rt_addr = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle(); advance();
        settle(); advance();

        // Reset state, then a WB pass-through write
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("rst_md_ready", obs_ready, 1'b1);
        chk1("rst_wb_hold", obs_hold, 1'b0);
        chk1("rst_wr_en", obs_en, 1'b0);
        advance();
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t1_wr_en", obs_en, 1'b1);
        advance();

        // MDU r8 queued behind three busy WB cycles
        id_rs_addr = 5'd8;
        drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd8, 32'hDEAD);
        settle(); chk1("t2_stall_arrive", obs_stall, 1'b1); advance();
        drive(1'b1, 5'd2, 32'd2, 1'b0, 5'd0, 32'd0);
        settle(); chk1("t2_stall_q1", obs_stall, 1'b1); advance();
        id_rs_addr = 5'd0;
        id_rt_addr = 5'd8;
        drive(1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 32'd0);
        settle(); chk1("t2_stall_rt", obs_stall, 1'b1); advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t2_idle_write", obs_en, 1'b1);
        chk("t2_idle_addr", 64'(obs_addr), 64'd8);
        chk1("t2_stall_writing", obs_stall, 1'b1);
        advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t2_stall_clear", obs_stall, 1'b0);
        chk1("t2_no_write", obs_en, 1'b0);
        chk("t2_drained", 64'(md_q.size()), 64'd0);
        advance();
        id_rt_addr = 5'd0;

        // Fill DEPTH=2 under continuous WB traffic
        drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd9, 32'h99);
        settle(); advance();
        drive(1'b1, 5'd2, 32'd2, 1'b1, 5'd10, 32'hA0);
        settle(); chk1("t3_ready_before_full", obs_ready, 1'b1); advance();
        drive(!obs_hold, 5'd4, 32'd4, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t3_hold", obs_hold, 1'b1);
        chk1("t3_ready_full", obs_ready, 1'b0);
        chk1("t3_bubble_write", obs_en, 1'b1);
        chk("t3_bubble_addr", 64'(obs_addr), 64'd9);
        advance();
        drive(!obs_hold, 5'd5, 32'd5, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t3_ready_back", obs_ready, 1'b1);
        chk1("t3_hold_drop", obs_hold, 1'b0);
        advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle(); chk("t3_r10_addr", 64'(obs_addr), 64'd10); advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t3_idle", obs_en, 1'b0);
        chk("t3_drained", 64'(md_q.size()), 64'd0);
        advance();

        // md_addr 0 is accepted and discarded
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        settle(); chk1("r0_ready", obs_ready, 1'b1); chk1("r0_no_write", obs_en, 1'b0); advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle(); chk1("r0_never_written", obs_en, 1'b0); advance();

        // WAW cancel of queued r12
        id_rs_addr = 5'd12;
        drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd12, 32'hAAAA);
        settle(); advance();
        drive(1'b1, 5'd12, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        settle(); chk1("t4_stall_before_cancel", obs_stall, 1'b1); advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t4_silent_pop", obs_en, 1'b0);
        chk1("t4_stall_cleared", obs_stall, 1'b0);
        advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t4_no_stale", obs_en, 1'b0);
        chk1("t4_ready", obs_ready, 1'b1);
        chk("t4_model_empty", 64'(md_q.size()), 64'd0);
        advance();
        id_rs_addr = 5'd0;

        // Starvation on the DEPTH=4 instance
        sel4 = 1'b1;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle(); advance();
        reset = 1'b0;
        drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd20, 32'h2020);
        settle(); advance();
        for (int k = 1; k <= 9; k++) begin
            drive(!obs_hold, 5'(k + 1), 32'(k), 1'b0, 5'd0, 32'd0);
            settle();
            chk1($sformatf("t5_hold_k%0d", k), obs_hold, k == 8);
            if (k == 8) begin
                chk1("t5_bubble_write", obs_en, 1'b1);
                chk("t5_bubble_addr", 64'(obs_addr), 64'd20);
            end
            advance();
        end
        chk("t5_drained", 64'(md_q.size()), 64'd0);

        // Reset with two entries queued and WB writing r3
        sel4 = 1'b0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle(); advance();
        reset = 1'b0;
        drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd21, 32'h21);
        settle(); advance();
        drive(1'b1, 5'd2, 32'd2, 1'b1, 5'd22, 32'h22);
        settle(); advance();
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        settle(); chk1("t6_rst_wr_en", obs_en, 1'b0); advance();
        reset = 1'b0;
        id_rs_addr = 5'd21;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk1("t6_ready", obs_ready, 1'b1);
        chk1("t6_hold", obs_hold, 1'b0);
        chk1("t6_stall", obs_stall, 1'b0);
        chk1("t6_no_write", obs_en, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            settle(); chk1("t6_no_late_write", obs_en, 1'b0); advance();
        end
        chk("final_model_empty", 64'(md_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
